// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths and control-bus bit indices for the ID/EX stage
//
// Purpose: one place for the control-bus layout so decode, ID/EX and execute
// agree on which bit means what.
//   WB bus : [REGWRITE, MEMTOREG]
//   M bus  : [BRANCH, MEMREAD, MEMWRITE]
//   EX bus : [JUMP, ALUSRC, ALUOP[1:0], REGDST]
package id_ex_stage_pkg;

  localparam int NB_DATA_DEF  = 32;
  localparam int NB_REG_DEF   = 5;
  localparam int NB_CTRL_WB   = 2;
  localparam int NB_CTRL_M    = 3;
  localparam int NB_CTRL_EX   = 5;
  localparam int NB_STALL_CNT = 16;

  // WB bus
  localparam int REGWRITE  = 1;
  localparam int MEMTOREG  = 0;
  // M bus
  localparam int BRANCH    = 2;
  localparam int MEMREAD   = 1;
  localparam int MEMWRITE  = 0;
  // EX bus
  localparam int JUMP      = 4;
  localparam int ALUSRC    = 3;
  localparam int ALUOP_MSB = 2;
  localparam int ALUOP_LSB = 1;
  localparam int REGDST    = 0;

  typedef logic [NB_STALL_CNT-1:0] stall_cnt_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use hazard detector
//
// Purpose: flags when the instruction in execute is a load whose destination
// (rt) is read by the instruction waiting in decode.
// Ports:
//   ex_valid_i    execute stage holds a real instruction
//   ex_mem_read_i MemRead bit of the execute-stage instruction
//   ex_rt_i       load destination register
//   id_valid_i    decode stage holds a real instruction
//   id_rs_i/id_rt_i  decode-stage source registers
//   stall_o       load-use hazard present
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEF
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [NB_REG-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  output logic              stall_o
);

  logic rt_match;

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign rt_match = (ex_rt_i != '0) && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign stall_o  = ex_valid_i && ex_mem_read_i && id_valid_i && rt_match;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and stall counter
//
// Purpose: captures decode-stage control and data for the execute stage,
// inserts a bubble on flush or load-use hazard, and counts stall cycles.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_enable              global advance; 0 freezes all state
//   i_flush               squash the decode-stage instruction
//   i_valid               decode stage holds a real instruction
//   i_ctrl_*_bus          decode control buses (WB/M/EX)
//   i_pc_next, i_rs_data, i_rt_data, i_imm_ext, i_rs, i_rt, i_rd  decode data
//   o_*                   registered copies for execute
//   o_valid               execute stage holds a real instruction
//   o_stall               load-use hazard, holds PC and IF/ID upstream
//   o_stall_count         saturating count of stall cycles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int NB_REG     = NB_REG_DEF,
  parameter int NB_CTRL_WB = id_ex_stage_pkg::NB_CTRL_WB,
  parameter int NB_CTRL_M  = id_ex_stage_pkg::NB_CTRL_M,
  parameter int NB_CTRL_EX = id_ex_stage_pkg::NB_CTRL_EX
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic [NB_DATA-1:0]    i_pc_next,
  input  logic [NB_DATA-1:0]    i_rs_data,
  input  logic [NB_DATA-1:0]    i_rt_data,
  input  logic [NB_DATA-1:0]    i_imm_ext,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic [NB_REG-1:0]     i_rd,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic [NB_DATA-1:0]    o_pc_next,
  output logic [NB_DATA-1:0]    o_rs_data,
  output logic [NB_DATA-1:0]    o_rt_data,
  output logic [NB_DATA-1:0]    o_imm_ext,
  output logic [NB_REG-1:0]     o_rs,
  output logic [NB_REG-1:0]     o_rt,
  output logic [NB_REG-1:0]     o_rd,
  output logic                  o_valid,
  output logic                  o_stall,
  output logic [15:0]           o_stall_count
);

  logic [NB_CTRL_WB-1:0] wb_q, wb_d;
  logic [NB_CTRL_M-1:0]  mem_q, mem_d;
  logic [NB_CTRL_EX-1:0] exc_q, exc_d;
  logic [NB_DATA-1:0]    pc_q, pc_d, rs_data_q, rs_data_d;
  logic [NB_DATA-1:0]    rt_data_q, rt_data_d, imm_q, imm_d;
  logic [NB_REG-1:0]     rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic                  valid_q, valid_d;
  stall_cnt_t            stall_count_q, stall_count_d;
  logic                  stall;

  hazard_detect #(
    .NB_REG (NB_REG)
  ) u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (mem_q[MEMREAD]),
    .ex_rt_i       (rt_q),
    .id_valid_i    (i_valid),
    .id_rs_i       (i_rs),
    .id_rt_i       (i_rt),
    .stall_o       (stall)
  );

  always_comb begin
    wb_d          = wb_q;
    mem_d         = mem_q;
    exc_d         = exc_q;
    pc_d          = pc_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rd_d          = rd_q;
    valid_d       = valid_q;
    stall_count_d = stall_count_q;
    if (i_enable) begin
      // Data fields load unconditionally; only control and valid carry meaning in a bubble.
      pc_d      = i_pc_next;
      rs_data_d = i_rs_data;
      rt_data_d = i_rt_data;
      imm_d     = i_imm_ext;
      rs_d      = i_rs;
      rt_d      = i_rt;
      rd_d      = i_rd;
      if (i_flush || stall) begin
        wb_d    = '0;
        mem_d   = '0;
        exc_d   = '0;
        valid_d = 1'b0;
      end else begin
        wb_d    = i_valid ? i_ctrl_wb_bus  : '0;
        mem_d   = i_valid ? i_ctrl_mem_bus : '0;
        exc_d   = i_valid ? i_ctrl_exc_bus : '0;
        valid_d = i_valid;
      end
      // A flushed stall is not a stall the upstream actually paid for.
      if (stall && !i_flush && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + stall_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_q          <= '0;
      mem_q         <= '0;
      exc_q         <= '0;
      pc_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      valid_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      wb_q          <= wb_d;
      mem_q         <= mem_d;
      exc_q         <= exc_d;
      pc_q          <= pc_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign o_ctrl_wb_bus  = wb_q;
  assign o_ctrl_mem_bus = mem_q;
  assign o_ctrl_exc_bus = exc_q;
  assign o_pc_next      = pc_q;
  assign o_rs_data      = rs_data_q;
  assign o_rt_data      = rt_data_q;
  assign o_imm_ext      = imm_q;
  assign o_rs           = rs_q;
  assign o_rt           = rt_q;
  assign o_rd           = rd_q;
  assign o_valid        = valid_q;
  assign o_stall        = stall;
  assign o_stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_enable, i_flush, i_valid;
  logic [1:0]  i_ctrl_wb_bus;
  logic [2:0]  i_ctrl_mem_bus;
  logic [4:0]  i_ctrl_exc_bus;
  logic [31:0] i_pc_next, i_rs_data, i_rt_data, i_imm_ext;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [1:0]  o_ctrl_wb_bus;
  logic [2:0]  o_ctrl_mem_bus;
  logic [4:0]  o_ctrl_exc_bus;
  logic [31:0] o_pc_next, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_valid, o_stall;
  logic [15:0] o_stall_count;

  int checks = 0;
  int failures = 0;

  // Model of what execute must hold, in instruction-level terms.
  logic [1:0]  m_wb;
  logic [2:0]  m_mem;
  logic [4:0]  m_ex;
  logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic        m_valid;
  logic        m_data_ok;
  int          m_count;

  always #5 i_clk = ~i_clk;

  id_ex_stage dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .i_ctrl_wb_bus  (i_ctrl_wb_bus),
    .i_ctrl_mem_bus (i_ctrl_mem_bus),
    .i_ctrl_exc_bus (i_ctrl_exc_bus),
    .i_pc_next      (i_pc_next),
    .i_rs_data      (i_rs_data),
    .i_rt_data      (i_rt_data),
    .i_imm_ext      (i_imm_ext),
    .i_rs           (i_rs),
    .i_rt           (i_rt),
    .i_rd           (i_rd),
    .o_ctrl_wb_bus  (o_ctrl_wb_bus),
    .o_ctrl_mem_bus (o_ctrl_mem_bus),
    .o_ctrl_exc_bus (o_ctrl_exc_bus),
    .o_pc_next      (o_pc_next),
    .o_rs_data      (o_rs_data),
    .o_rt_data      (o_rt_data),
    .o_imm_ext      (o_imm_ext),
    .o_rs           (o_rs),
    .o_rt           (o_rt),
    .o_rd           (o_rd),
    .o_valid        (o_valid),
    .o_stall        (o_stall),
    .o_stall_count  (o_stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A load in execute blocks a decode instruction that reads its destination.
  function automatic logic model_stall();
    return m_valid && m_mem[1] && (m_rt != 5'd0) && i_valid &&
           ((m_rt == i_rs) || (m_rt == i_rt));
  endfunction

  task automatic model_reset();
    m_wb = '0; m_mem = '0; m_ex = '0;
    m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_valid = 1'b0; m_data_ok = 1'b1; m_count = 0;
  endtask

  task automatic model_edge();
    logic st;
    if (i_rst) begin
      model_reset();
    end else if (i_enable) begin
      st = model_stall();
      if (st && !i_flush && m_count < 65535) m_count++;
      if (i_flush || st) begin
        m_wb = '0; m_mem = '0; m_ex = '0; m_valid = 1'b0; m_data_ok = 1'b0;
      end else begin
        m_valid = i_valid;
        m_wb  = i_valid ? i_ctrl_wb_bus  : 2'b0;
        m_mem = i_valid ? i_ctrl_mem_bus : 3'b0;
        m_ex  = i_valid ? i_ctrl_exc_bus : 5'b0;
        m_pc = i_pc_next; m_rsd = i_rs_data; m_rtd = i_rt_data; m_imm = i_imm_ext;
        m_rs = i_rs; m_rt = i_rt; m_rd = i_rd; m_data_ok = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("stall", 32'(o_stall), 32'(model_stall()));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("wb", 32'(o_ctrl_wb_bus), 32'(m_wb));
    chk("mem", 32'(o_ctrl_mem_bus), 32'(m_mem));
    chk("exc", 32'(o_ctrl_exc_bus), 32'(m_ex));
    chk("count", 32'(o_stall_count), 32'(m_count));
    if (m_data_ok) begin
      chk("pc", o_pc_next, m_pc);
      chk("rs_data", o_rs_data, m_rsd);
      chk("rt_data", o_rt_data, m_rtd);
      chk("imm", o_imm_ext, m_imm);
      chk("rs", 32'(o_rs), 32'(m_rs));
      chk("rt", 32'(o_rt), 32'(m_rt));
      chk("rd", 32'(o_rd), 32'(m_rd));
    end
  endtask

  // Compare the settled state, take one clock edge, return on the falling edge.
  task automatic step();
    #1 compare_all();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [4:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] base);
    i_valid = v; i_ctrl_wb_bus = wb; i_ctrl_mem_bus = m; i_ctrl_exc_bus = ex;
    i_rs = rs; i_rt = rt; i_rd = rd;
    i_pc_next = base; i_rs_data = base + 32'd1; i_rt_data = base + 32'd2; i_imm_ext = base + 32'd3;
  endtask

  task automatic drive_lw(input logic [4:0] rt, input logic [31:0] base);
    drive(1'b1, 2'b11, 3'b010, 5'b01000, 5'd1, rt, 5'd0, base);
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [31:0] base);
    drive(1'b1, 2'b10, 3'b000, 5'b00101, rs, 5'd6, 5'd7, base);
  endtask

  logic [31:0] r;

  initial begin
    i_rst = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
    drive(1'b0, 2'b0, 3'b0, 5'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    model_reset();
    repeat (2) @(negedge i_clk);
    compare_all();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    i_rst = 1'b0;

    // R-type passes straight through with one edge of latency.
    drive(1'b1, 2'b10, 3'b000, 5'b00101, 5'd2, 5'd3, 5'd4, 32'h0000_0104);
    step();
    chk("rtype_wb", 32'(o_ctrl_wb_bus), 32'h2);
    chk("rtype_exc", 32'(o_ctrl_exc_bus), 32'h5);
    chk("rtype_regs", {17'd0, o_rs, o_rt, o_rd}, 32'h0000_0864);
    chk("rtype_pc", o_pc_next, 32'h104);
    chk("rtype_valid", 32'(o_valid), 32'd1);

    // LW r5 then ADD reading r5: one bubble, then the ADD.
    drive_lw(5'd5, 32'h200);
    step();
    drive_add(5'd5, 32'h300);
    #1 chk("lu_stall", 32'(o_stall), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(o_valid), 32'd0);
    chk("lu_bubble_mem", 32'(o_ctrl_mem_bus), 32'd0);
    chk("lu_stall_gone", 32'(o_stall), 32'd0);
    chk("lu_count", 32'(o_stall_count), 32'd1);
    step();
    chk("lu_add_rd", 32'(o_rd), 32'd7);
    chk("lu_add_valid", 32'(o_valid), 32'd1);

    // A load into r0 never stalls.
    drive_lw(5'd0, 32'h400);
    step();
    drive_add(5'd0, 32'h500);
    #1 chk("r0_nostall", 32'(o_stall), 32'd0);
    step();
    chk("r0_count", 32'(o_stall_count), 32'd1);

    // Flush coincident with a stall: bubble, no count.
    drive_lw(5'd5, 32'h600);
    step();
    drive_add(5'd5, 32'h700);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_stall_count", 32'(o_stall_count), 32'd1);
    step();
    // Flush with a load at the input: all control cleared.
    drive_lw(5'd9, 32'h800);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_ctrl", {27'd0, o_ctrl_wb_bus, o_ctrl_mem_bus}, 32'd0);
    chk("flush_exc", 32'(o_ctrl_exc_bus), 32'd0);
    // Non-valid decode loads zero control.
    drive(1'b0, 2'b11, 3'b111, 5'b11111, 5'd1, 5'd2, 5'd3, 32'h900);
    step();
    chk("nonvalid_mem", 32'(o_ctrl_mem_bus), 32'd0);

    // Freeze while a hazard is present: nothing moves, stall still reported.
    drive_lw(5'd5, 32'hA00);
    step();
    i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      drive(1'b1, r[1:0], r[4:2], r[9:5], 5'd5, r[14:10], r[19:15], r);
      step();
    end
    chk("freeze_rt", 32'(o_rt), 32'd5);
    chk("freeze_count", 32'(o_stall_count), 32'd1);
    chk("freeze_stall", 32'(o_stall), 32'd1);
    i_enable = 1'b1;
    step();
    chk("unfreeze_count", 32'(o_stall_count), 32'd2);

    // Reset between edges, mid-stall.
    drive_lw(5'd5, 32'hB00);
    step();
    drive_add(5'd5, 32'hC00);
    #2 i_rst = 1'b1;
    #1 model_reset();
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_wb", 32'(o_ctrl_wb_bus), 32'd0);
    chk("arst_pc", o_pc_next, 32'd0);
    chk("arst_count", 32'(o_stall_count), 32'd0);
    chk("arst_stall", 32'(o_stall), 32'd0);
    step();
    i_rst = 1'b0;
    step();
    chk("post_rst_rd", 32'(o_rd), 32'd7);
    chk("post_rst_valid", 32'(o_valid), 32'd1);

    // Saturation: preload near the top, then push through it.
    force dut.stall_count_q = 16'hFFFC;
    #1 release dut.stall_count_q;
    m_count = 32'hFFFC;
    for (int k = 0; k < 5; k++) begin
      drive_lw(5'd5, 32'hD00 + 32'(k));
      step();
      drive_add(5'd5, 32'hE00 + 32'(k));
      step();
    end
    chk("sat_count", 32'(o_stall_count), 32'hFFFF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
